// File: rtl/id_pkg.sv
// Shared encodings and constants for the identifier generator and its recognizer.
package id_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ALPHA  = 2'd1,
        NUM    = 2'd2,
        TERM_S = 2'd3
    } gen_state_t;

    typedef enum logic [1:0] {
        REC_NULL  = 2'd0,
        REC_ALPHA = 2'd1,
        REC_NUM   = 2'd2
    } rec_state_t;

    localparam logic [7:0] CH_a    = 8'h61;
    localparam logic [7:0] CH_A    = 8'h41;
    localparam logic [7:0] CH_0    = 8'h30;
    localparam logic [7:0] CH_TERM = 8'h3B;

    localparam int ALPHA_MOD = 26;
    localparam int DIGIT_MOD = 10;

    // Out-of-range alphabet indices restart at the first letter.
    function automatic logic [4:0] clamp_letter(input logic [4:0] f);
        return (f >= 5'(ALPHA_MOD)) ? 5'd0 : f;
    endfunction

endpackage

// File: rtl/id_gen_cnt.sv
// Loadable modulo-N up-counter; exposes the value it will take on the next enable.
module id_gen_cnt #(
    parameter int N = 10,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic [W-1:0] o_next
);

    localparam logic [W-1:0] MAX = W'(N - 1);
    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] r_q;

    assign o_next = (r_q == MAX) ? '0 : r_q + ONE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_load_val;
        end else if (i_en) begin
            r_q <= o_next;
        end
    end

endmodule

// File: rtl/id_gen.sv
// Identifier stream generator: letters, then digits, then a terminator,
// one registered character per cycle.
module id_gen
    import id_pkg::*;
#(
    parameter int         LEN_W = 4,
    parameter bit         UPPER = 1'b0,
    parameter logic [7:0] TERM  = CH_TERM
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] alpha_len,
    input  logic [LEN_W-1:0] num_len,
    input  logic [4:0]       first_letter,
    input  logic             hold,
    output logic [7:0]       char,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);
    localparam logic [7:0] BASE = UPPER ? CH_A : CH_a;

    gen_state_t       r_state, w_state_nxt;
    logic [LEN_W-1:0] r_run, w_run_nxt;
    logic [LEN_W-1:0] r_num;
    logic [7:0]       r_char, w_char_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic             r_err, w_err_nxt;
    logic             w_accept;
    logic             w_let_ld, w_let_en;
    logic             w_dig_ld, w_dig_en;
    logic [4:0]       w_first;
    logic [4:0]       w_let_next;
    logic [3:0]       w_dig_next;

    assign w_first = clamp_letter(first_letter);

    id_gen_cnt #(.N(ALPHA_MOD), .W(5)) u_let (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_let_ld),
        .i_load_val(w_first),
        .i_en      (w_let_en),
        .o_next    (w_let_next)
    );

    id_gen_cnt #(.N(DIGIT_MOD), .W(4)) u_dig (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_dig_ld),
        .i_load_val(4'd0),
        .i_en      (w_dig_en),
        .o_next    (w_dig_next)
    );

    // The character for each cycle is computed one edge ahead, so the
    // state names the run whose character is currently on the output.
    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        w_char_nxt  = r_char;
        w_valid_nxt = r_valid;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_accept    = 1'b0;
        w_let_ld    = 1'b0;
        w_let_en    = 1'b0;
        w_dig_ld    = 1'b0;
        w_dig_en    = 1'b0;
        if (!hold) begin
            unique case (r_state)
                IDLE: begin
                    w_valid_nxt = 1'b0;
                    if (start && alpha_len != '0) begin
                        w_accept    = 1'b1;
                        w_let_ld    = 1'b1;
                        w_state_nxt = ALPHA;
                        w_run_nxt   = alpha_len - ONE;
                        w_char_nxt  = BASE + {3'b000, w_first};
                        w_valid_nxt = 1'b1;
                        w_busy_nxt  = 1'b1;
                    end else if (start) begin
                        w_err_nxt = 1'b1;
                    end
                end
                ALPHA: begin
                    if (r_run != '0) begin
                        w_let_en   = 1'b1;
                        w_run_nxt  = r_run - ONE;
                        w_char_nxt = BASE + {3'b000, w_let_next};
                    end else if (r_num != '0) begin
                        w_dig_ld    = 1'b1;
                        w_state_nxt = NUM;
                        w_run_nxt   = r_num - ONE;
                        w_char_nxt  = CH_0;
                    end else begin
                        w_state_nxt = TERM_S;
                        w_char_nxt  = TERM;
                    end
                end
                NUM: begin
                    if (r_run != '0) begin
                        w_dig_en   = 1'b1;
                        w_run_nxt  = r_run - ONE;
                        w_char_nxt = CH_0 + {4'b0000, w_dig_next};
                    end else begin
                        w_state_nxt = TERM_S;
                        w_char_nxt  = TERM;
                    end
                end
                TERM_S: begin
                    w_state_nxt = IDLE;
                    w_valid_nxt = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_run   <= '0;
            r_num   <= '0;
            r_char  <= 8'h00;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= w_run_nxt;
            r_char  <= w_char_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            if (w_accept) begin
                r_num <= num_len;
            end
        end
    end

    assign char  = r_char;
    assign valid = r_valid;
    assign busy  = r_busy;
    assign done  = r_done;
    assign err   = r_err;

endmodule

// File: tb/tb_id_gen.sv
// Directed bench for id_gen: streams, wraps, rejects, hold and mid-stream reset.
module tb_id_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] alpha_len = 4'd0;
    logic [3:0] num_len = 4'd0;
    logic [4:0] first_letter = 5'd0;
    logic       hold = 1'b0;
    logic [7:0] char;
    logic       valid;
    logic       busy;
    logic       done;
    logic       err;

    int checks = 0;
    int errors = 0;

    id_gen #(.LEN_W(4), .UPPER(1'b0), .TERM(8'h3B)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .alpha_len   (alpha_len),
        .num_len     (num_len),
        .first_letter(first_letter),
        .hold        (hold),
        .char        (char),
        .valid       (valid),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Called at a falling edge; returns at the falling edge where the
    // first character is visible.
    task automatic kick(input logic [3:0] al, input logic [3:0] nl,
                        input logic [4:0] fl);
        alpha_len    = al;
        num_len      = nl;
        first_letter = fl;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({char, valid, busy, done, err} !== 12'h000) begin
            errors++;
            $display("FAIL reset_state got c=%h v=%b b=%b d=%b e=%b want all 0",
                     char, valid, busy, done, err);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({valid, busy, done, err} !== 4'b0000) begin
            errors++;
            $display("FAIL idle_after_reset got v=%b b=%b d=%b e=%b want 0000",
                     valid, busy, done, err);
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp [6] = '{"y", "z", "0", "1", "2", ";"};
        kick(4'd2, 4'd3, 5'd24);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if ({valid, busy, done, char} !== {3'b110, exp[i]}) begin
                errors++;
                $display("FAIL basic[%0d] got v=%b b=%b d=%b c=%h want 110 c=%h",
                         i, valid, busy, done, char, exp[i]);
            end
        end
        @(negedge clk);
        checks++;
        if ({done, busy, valid} !== 3'b100) begin
            errors++;
            $display("FAIL basic_done got d=%b b=%b v=%b want 100",
                     done, busy, valid);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_once got d=%b want 0", done);
        end
    endtask

    task automatic test_zero_digits();
        logic [7:0] exp [2] = '{"a", ";"};
        kick(4'd1, 4'd0, 5'd0);
        for (int i = 0; i < 2; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if ({valid, busy, char} !== {2'b11, exp[i]}) begin
                errors++;
                $display("FAIL zero_dig[%0d] got v=%b b=%b c=%h want c=%h",
                         i, valid, busy, char, exp[i]);
            end
        end
        @(negedge clk);
        checks++;
        if ({done, busy, valid} !== 3'b100) begin
            errors++;
            $display("FAIL zero_dig_done got d=%b b=%b v=%b want 100",
                     done, busy, valid);
        end
    endtask

    task automatic test_letter_wrap();
        logic [7:0] exp [4] = '{"z", "a", "b", ";"};
        kick(4'd3, 4'd0, 5'd25);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if ({valid, char} !== {1'b1, exp[i]}) begin
                errors++;
                $display("FAIL letter_wrap[%0d] got v=%b c=%h want c=%h",
                         i, valid, char, exp[i]);
            end
        end
        @(negedge clk);
        kick(4'd1, 4'd0, 5'd31);
        checks++;
        if ({valid, char} !== {1'b1, 8'h61}) begin
            errors++;
            $display("FAIL letter_clamp got v=%b c=%h want c=61", valid, char);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_digit_wrap();
        logic [7:0] exp [14] = '{"a", "0", "1", "2", "3", "4", "5",
                                 "6", "7", "8", "9", "0", "1", ";"};
        kick(4'd1, 4'd12, 5'd0);
        for (int i = 0; i < 14; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if ({valid, busy, char} !== {2'b11, exp[i]}) begin
                errors++;
                $display("FAIL digit_wrap[%0d] got v=%b b=%b c=%h want c=%h",
                         i, valid, busy, char, exp[i]);
            end
        end
        @(negedge clk);
        checks++;
        if ({done, valid} !== 2'b10) begin
            errors++;
            $display("FAIL digit_wrap_done got d=%b v=%b want 10", done, valid);
        end
    endtask

    task automatic test_reject();
        alpha_len = 4'd0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({err, valid, busy} !== 3'b100) begin
            errors++;
            $display("FAIL reject_err got e=%b v=%b b=%b want 100",
                     err, valid, busy);
        end
        @(negedge clk);
        checks++;
        if ({err, valid, busy} !== 3'b000) begin
            errors++;
            $display("FAIL reject_err_once got e=%b v=%b b=%b want 000",
                     err, valid, busy);
        end
        alpha_len = 4'd2;
        start     = 1'b1;
        hold      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hold  = 1'b0;
        checks++;
        if ({err, valid, busy} !== 3'b000) begin
            errors++;
            $display("FAIL start_under_hold got e=%b v=%b b=%b want 000",
                     err, valid, busy);
        end
        @(negedge clk);
        checks++;
        if ({err, valid, busy} !== 3'b000) begin
            errors++;
            $display("FAIL start_under_hold_idle got e=%b v=%b b=%b want 000",
                     err, valid, busy);
        end
    endtask

    task automatic test_start_while_busy();
        logic [7:0] exp [5] = '{"d", "e", "0", "1", ";"};
        kick(4'd2, 4'd2, 5'd3);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if ({valid, err, char} !== {2'b10, exp[i]}) begin
                errors++;
                $display("FAIL busy_start[%0d] got v=%b e=%b c=%h want v=1 e=0 c=%h",
                         i, valid, err, char, exp[i]);
            end
            if (i == 1) begin
                start     = 1'b1;
                alpha_len = 4'd0;
                num_len   = 4'd7;
            end else if (i == 2) begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if ({done, err} !== 2'b10) begin
            errors++;
            $display("FAIL busy_start_done got d=%b e=%b want 10", done, err);
        end
    endtask

    task automatic test_hold();
        logic [7:0] exp [9] = '{"a", "b", "b", "b", "b", "c", "0", ";", ";"};
        logic       hnx [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
                                1'b0, 1'b0, 1'b1, 1'b0};
        kick(4'd3, 4'd1, 5'd0);
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if ({valid, busy, done, char} !== {3'b110, exp[i]}) begin
                errors++;
                $display("FAIL hold[%0d] got v=%b b=%b d=%b c=%h want 110 c=%h",
                         i, valid, busy, done, char, exp[i]);
            end
            hold = hnx[i];
        end
        @(negedge clk);
        checks++;
        if ({done, busy, valid} !== 3'b100) begin
            errors++;
            $display("FAIL hold_done got d=%b b=%b v=%b want 100",
                     done, busy, valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp [4] = '{"f", "g", "0", ";"};
        kick(4'd1, 4'd4, 5'd0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({valid, char} !== {1'b1, 8'h31}) begin
            errors++;
            $display("FAIL pre_reset got v=%b c=%h want v=1 c=31", valid, char);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({char, valid, busy} !== 10'd0) begin
            errors++;
            $display("FAIL async_reset got c=%h v=%b b=%b want 0", char, valid, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        kick(4'd2, 4'd1, 5'd5);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if ({valid, busy, char} !== {2'b11, exp[i]}) begin
                errors++;
                $display("FAIL after_reset[%0d] got v=%b b=%b c=%h want c=%h",
                         i, valid, busy, char, exp[i]);
            end
        end
        @(negedge clk);
        checks++;
        if ({done, busy, valid} !== 3'b100) begin
            errors++;
            $display("FAIL after_reset_done got d=%b b=%b v=%b want 100",
                     done, busy, valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_digits();
        test_letter_wrap();
        test_digit_wrap();
        test_reject();
        test_start_while_busy();
        test_hold();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
